// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants for the multiply/divide unit (op encodings,
// operation latencies, controller state encoding). Imported by mdu_ctrl and
// by the hazard/decode logic so every consumer agrees on the same values.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MADDU = 3'd5;
  localparam logic [2:0] OP_MSUB  = 3'd6;
  localparam logic [2:0] OP_MSUBU = 3'd7;

  localparam logic [4:0] MUL_CYCLES = 5'd5;
  localparam logic [4:0] DIV_CYCLES = 5'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  // True for the two divide encodings.
  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // True for the accumulate family (madd/maddu/msub/msubu).
  function automatic logic is_acc_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide controller owning architectural HI/LO.
// Operands are latched on the start edge; the result is committed on the last
// busy edge, so HI/LO change in the same cycle busy drops.
// Build option: define MDU_MADD_EN to enable madd/maddu/msub/msubu (ops 4-7).
// Without it those ops are ignored and no accumulate logic is built.
//
// Handshake: start is a single-cycle issue pulse, accepted only in IDLE.
// stall_req = start | busy holds the pipeline, so a legal start never arrives
// while busy; an illegal one is simply dropped. flush cancels everything
// sampled on the same edge, including a pending commit.
module mdu_ctrl
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic        flush,
  output logic        busy,
  output logic [4:0]  busy_cnt,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output mdu_state_e  state_dbg
);

  mdu_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q;
  logic [31:0] rs_q, rt_q, hi_q, lo_q;
  logic        start_mul, start_div, load, commit, res_we, hi_wr, lo_wr;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u, res;
  logic [31:0] divisor;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0] quot_u, rem_u;

  // Decode which kind of operation a start would launch.
  always_comb begin
    start_div = start & is_div_op(op);
`ifdef MDU_MADD_EN
    start_mul = start & ~is_div_op(op);
`else
    start_mul = start & ~is_div_op(op) & ~is_acc_op(op);
`endif
  end

  // Next-state, countdown and commit decision; flush overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    load    = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = 5'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_div) begin
            state_d = ST_DIV;
            cnt_d   = DIV_CYCLES;
            load    = 1'b1;
          end else if (start_mul) begin
            state_d = ST_MUL;
            cnt_d   = MUL_CYCLES;
            load    = 1'b1;
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt_q == 5'd1) begin
            commit  = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 5'd0;
        end
      endcase
    end
  end

  // mthi/mtlo land only when idle, with no start and no flush on this edge.
  always_comb begin
    hi_wr = hi_we & (state_q == ST_IDLE) & ~start & ~flush;
    lo_wr = lo_we & (state_q == ST_IDLE) & ~start & ~flush;
  end

  // Behavioural arithmetic on the latched operands; a zero divisor is
  // replaced by 1 only to keep the divider defined, its result is discarded.
  always_comb begin
    prod_s  = $signed({{32{rs_q[31]}}, rs_q}) * $signed({{32{rt_q[31]}}, rt_q});
    prod_u  = {32'd0, rs_q} * {32'd0, rt_q};
    divisor = (rt_q == 32'd0) ? 32'd1 : rt_q;
    quot_s  = $signed(rs_q) / $signed(divisor);
    rem_s   = $signed(rs_q) % $signed(divisor);
    quot_u  = rs_q / divisor;
    rem_u   = rs_q % divisor;
    case (op_q)
      OP_MULT:  res = $unsigned(prod_s);
      OP_MULTU: res = prod_u;
      OP_DIV:   res = {$unsigned(rem_s), $unsigned(quot_s)};
      OP_DIVU:  res = {rem_u, quot_u};
`ifdef MDU_MADD_EN
      OP_MADD:  res = {hi_q, lo_q} + $unsigned(prod_s);
      OP_MADDU: res = {hi_q, lo_q} + prod_u;
      OP_MSUB:  res = {hi_q, lo_q} - $unsigned(prod_s);
      OP_MSUBU: res = {hi_q, lo_q} - prod_u;
`endif
      default:  res = {hi_q, lo_q};
    endcase
    res_we = commit & ~(is_div_op(op_q) & (rt_q == 32'd0));
  end

  // State, countdown, operand latch and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 3'd0;
      rs_q    <= 32'd0;
      rt_q    <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        op_q <= op;
        rs_q <= rs_val;
        rt_q <= rt_val;
      end
      if (res_we) begin
        hi_q <= res[63:32];
        lo_q <= res[31:0];
      end else begin
        if (hi_wr) hi_q <= rs_val;
        if (lo_wr) lo_q <= rs_val;
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign busy_cnt  = cnt_q;
  assign stall_req = start | busy;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign state_dbg = state_q;

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = asserted).
REQ-003 SHALL have port start, input, 1 bit: the E-stage mult/div/madd instruction issues this cycle.
REQ-004 SHALL have port op, input, 3 bits: 0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 maddu, 6 msub, 7 msubu.
REQ-005 SHALL have ports rs_val and rt_val, inputs, 32 bits each: the operands.
REQ-006 SHALL have ports hi_we and lo_we, inputs, 1 bit each: mthi/mtlo write enables; write data is rs_val.
REQ-007 SHALL have port flush, input, 1 bit: exception or eret cancel from CP0.
REQ-008 SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-009 SHALL have port busy_cnt, output, 5 bits: remaining cycles of the current operation.
REQ-010 SHALL have port stall_req, output, 1 bit: combinational (start | busy), routed to the hazard unit.
REQ-011 SHALL have ports hi and lo, outputs, 32 bits each: architectural HI and LO.

Function
REQ-012 SHALL implement states IDLE, MUL and DIV.
REQ-013 IDLE SHALL transition to MUL on start with op in {0,1,4,5,6,7}, and to DIV on start with op in {2,3}.
REQ-014 On the start edge, SHALL latch the operands and op, set busy_cnt = 5 (MUL) or 10 (DIV), and assert busy.
REQ-015 SHALL decrement busy_cnt each edge while busy; the edge where busy_cnt==1 commits HI/LO, clears busy_cnt to 0, and returns to IDLE.
REQ-016 Timing: busy is high for exactly N cycles after the start edge, and the new HI/LO are visible in the same cycle busy drops.
REQ-017 mult/multu SHALL produce the 64-bit signed/unsigned product, {HI,LO} = rs*rt.
REQ-018 madd(u)/msub(u) SHALL compute {HI,LO} = {HI,LO} +/- product, modulo 2^64, using the HI/LO value at commit time.
REQ-019 div/divu SHALL set LO = quotient and HI = remainder; signed division truncates toward zero and the remainder takes the sign of the dividend.
REQ-020 Divide by zero SHALL leave HI and LO unchanged; timing SHALL be as for a normal div.
REQ-021 start while busy SHALL be ignored; stall_req guarantees this never happens legally.
REQ-022 hi_we/lo_we SHALL write HI/LO on the edge only when in IDLE and start is 0; otherwise they are ignored.
REQ-023 start asserted together with hi_we or lo_we SHALL take priority; the writes are dropped.
REQ-024 flush SHALL abort any in-flight operation: state goes to IDLE, busy_cnt to 0, and HI/LO are not modified.
REQ-025 flush SHALL suppress a start or hi_we/lo_we sampled on the same edge.
REQ-026 flush coincident with the commit edge (busy_cnt==1) SHALL still suppress the commit.

Reset
REQ-027 While reset is low, SHALL immediately force state IDLE, busy 0, busy_cnt 0, hi 0, lo 0, and clear the latched operands.
REQ-028 Reset asserted mid-operation SHALL discard the operation; after release the block accepts start on the first rising edge.

Configuration
REQ-029 Macro MDU_MADD_EN defined: ops 4-7 SHALL behave per REQ-018 with 5-cycle latency.
REQ-030 MDU_MADD_EN undefined: start with op 4-7 SHALL be ignored, busy stays 0, and stall_req = start only; the accumulate logic is not synthesized.

Structure
REQ-031 Shared package mdu_pkg SHALL hold the op encodings, MUL_CYCLES=5, DIV_CYCLES=10, and the state encoding; hazard and decode logic import the same constants.
REQ-032 Single module, no sub-module; the arithmetic is inline behavioural multiply/divide on the latched operands.

Verification
REQ-033 mult rs=0xFFFFFFFF, rt=2 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-034 div rs=-7 (0xFFFFFFF9), rt=2 -> busy_cnt counts 10..1, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/0 -> hi/lo unchanged after 10 cycles.
REQ-035 mthi 0x1234 while busy -> ignored; mthi 0x1234 in IDLE -> hi=0x00001234 next cycle; start+lo_we on the same cycle -> the lo write is dropped.
REQ-036 div started, flush at busy_cnt=1 -> busy drops next cycle, hi/lo keep their pre-div values; start+flush on the same edge -> busy stays 0.
REQ-037 With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, maddu rs=1, rt=1 -> hi=1, lo=0 after 5 cycles. Without the macro: the same stimulus -> busy never rises.
REQ-038 reset low at busy_cnt=3 -> outputs go to 0 immediately, without a clock edge; after release, mult 3*4 -> lo=12, hi=0.
